// File: rtl/isqrt_param.sv
// Sequential integer square root: restoring bit-pair iteration, one root bit per clock,
// with floor remainder, optional saturating round-to-nearest and busy/done handshake.
module isqrt_param #(
  parameter int WIDTH = 8,
  parameter int ROUND = 0
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  output logic               busy,
  output logic               done,
  output logic [WIDTH/2-1:0] sqrt,
  output logic [WIDTH/2:0]   rem
);
  localparam int R  = WIDTH / 2;
  localparam int CW = (R > 1) ? $clog2(R) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [R-1:0]     r_root;
  logic [R+1:0]     r_work;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [R-1:0]     r_sqrt;
  logic [R:0]       r_rem;

  logic [R+1:0]     w_w;
  logic [R+1:0]     w_t;
  logic [R+1:0]     w_r_next;
  logic [R-1:0]     w_q_next;
  logic [R-1:0]     w_sqrt;
  logic             w_ge;

  // One restoring step: bring down the next radicand bit pair and try subtracting 4q+1.
  always_comb begin
    w_w  = (r_work << 2) | {{R{1'b0}}, r_a[WIDTH-1 -: 2]};
    w_t  = {r_root, 2'b01};
    w_ge = (w_w >= w_t);
    if (w_ge) begin
      w_r_next = w_w - w_t;
    end else begin
      w_r_next = w_w;
    end
    w_q_next = (r_root << 1) | R'(w_ge);
  end

  // Rounding: remainder above the floor root means sqrt(a) >= q + 0.5; all-ones root saturates.
  always_comb begin
    w_sqrt = w_q_next;
    if ((ROUND != 0) && (w_r_next > {2'b00, w_q_next}) && !(&w_q_next)) begin
      w_sqrt = w_q_next + R'(1'b1);
    end else begin
      w_sqrt = w_q_next;
    end
  end

  // Control FSM, iteration state and result registers; clr overrides everything.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_root  <= '0;
      r_work  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sqrt  <= '0;
      r_rem   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_a     <= a;
            r_root  <= '0;
            r_work  <= '0;
            r_cnt   <= CW'(R - 1);
            r_busy  <= 1'b1;
            r_state <= CALC;
          end else begin
            r_state <= IDLE;
          end
        end
        CALC: begin
          r_a    <= r_a << 2;
          r_root <= w_q_next;
          r_work <= w_r_next;
          r_cnt  <= r_cnt - CW'(1);
          if (r_cnt == '0) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_sqrt  <= w_sqrt;
            r_rem   <= w_r_next[R:0];
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sqrt = r_sqrt;
  assign rem  = r_rem;
endmodule

// File: tb/tb_isqrt_param.sv
// Scoreboard bench for isqrt_param: W=8 floor, W=8 rounded and W=16 floor instances
// checked against an arithmetic reference model, including latency and busy timing.
module tb_isqrt_param;
  logic clk;
  logic clr;
  logic st0, st1, st2;
  logic [7:0] a0, a1;
  logic [15:0] a2;
  logic b0, b1, b2, d0, d1, d2;
  logic [3:0] s0, s1;
  logic [4:0] r0, r1;
  logic [7:0] s2;
  logic [8:0] r2;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  typedef struct { longint sq; longint rm; int k; int due; } exp_t;
  exp_t sb[3][$];

  isqrt_param #(.WIDTH(8), .ROUND(0)) u0 (.clk(clk), .clr(clr), .start(st0), .a(a0),
    .busy(b0), .done(d0), .sqrt(s0), .rem(r0));
  isqrt_param #(.WIDTH(8), .ROUND(1)) u1 (.clk(clk), .clr(clr), .start(st1), .a(a1),
    .busy(b1), .done(d1), .sqrt(s1), .rem(r1));
  isqrt_param #(.WIDTH(16), .ROUND(0)) u2 (.clk(clk), .clr(clr), .start(st2), .a(a2),
    .busy(b2), .done(d2), .sqrt(s2), .rem(r2));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rw(input int d);
    return (d == 2) ? 8 : 4;
  endfunction

  // Reference: search for the floor root, round by comparing 4a with (2x+1)^2.
  task automatic ref_model(input longint av, input int d, output longint sq, output longint rm);
    longint x;
    longint mx;
    x = 0;
    while ((x + 1) * (x + 1) <= av) x++;
    rm = av - x * x;
    sq = x;
    mx = (longint'(1) << rw(d)) - 1;
    if (d == 1 && 4 * av >= (2 * x + 1) * (2 * x + 1)) sq = x + 1;
    if (sq > mx) sq = mx;
  endtask

  task automatic chk(input string nm, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, got, want);
    end
  endtask

  task automatic mon(input int d, input logic bz, input logic dn, input longint s, input longint r);
    exp_t e;
    logic eb;
    if (dn === 1'b1) begin
      checks++;
      if (sb[d].size() == 0) begin
        errors++;
        $display("FAIL unexpected_done dut%0d cyc=%0d got done=1 want done=0", d, cyc);
      end else begin
        e = sb[d].pop_front();
        if (cyc != e.due || s != e.sq || r != e.rm) begin
          errors++;
          $display("FAIL result dut%0d got sqrt=%0d rem=%0d at cyc %0d want sqrt=%0d rem=%0d at cyc %0d",
                   d, s, r, cyc, e.sq, e.rm, e.due);
        end
      end
    end else if (sb[d].size() != 0 && cyc >= sb[d][0].due) begin
      e = sb[d].pop_front();
      checks++;
      errors++;
      $display("FAIL missing_done dut%0d cyc=%0d got done=0 want done=1", d, cyc);
    end
    eb = (sb[d].size() != 0) && (sb[d][0].k <= cyc) && (cyc < sb[d][0].due);
    checks++;
    if (bz !== eb) begin
      errors++;
      $display("FAIL busy dut%0d cyc=%0d got=%b want=%b", d, cyc, bz, eb);
    end
  endtask

  // Monitor: compare on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, b0, d0, longint'(s0), longint'(r0));
      mon(1, b1, d1, longint'(s1), longint'(r1));
      mon(2, b2, d2, longint'(s2), longint'(r2));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Raise start for DUT d; the next rising edge accepts it.
  task automatic start_op(input int d, input longint av);
    exp_t e;
    ref_model(av, d, e.sq, e.rm);
    e.k = cyc + 1;
    e.due = e.k + rw(d);
    case (d)
      0: begin st0 = 1'b1; a0 = av[7:0]; end
      1: begin st1 = 1'b1; a1 = av[7:0]; end
      default: begin st2 = 1'b1; a2 = av[15:0]; end
    endcase
    sb[d].push_back(e);
  endtask

  task automatic drop_starts();
    st0 = 1'b0;
    st1 = 1'b0;
    st2 = 1'b0;
  endtask

  // Single op; returns in the DONE cycle so the next op can go back-to-back.
  task automatic go(input int d, input longint av);
    start_op(d, av);
    tick();
    drop_starts();
    ticks(rw(d));
  endtask

  initial begin
    clr = 1'b1;
    drop_starts();
    a0 = 8'd0; a1 = 8'd0; a2 = 16'd0;
    ticks(3);
    clr = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("reset_done0", longint'(d0), 0);
    chk("reset_sqrt0", longint'(s0), 0);
    chk("reset_rem0", longint'(r0), 0);
    chk("reset_sqrt1", longint'(s1), 0);
    chk("reset_rem2", longint'(r2), 0);
    tick();

    go(0, 0);
    go(0, 200);
    go(0, 255);
    go(0, 144);
    tick();
    go(1, 210);
    go(1, 211);
    go(1, 255);
    ticks(2);

    // Start pulsed mid-calculation must be ignored.
    start_op(0, 100);
    tick();
    drop_starts();
    tick();
    st0 = 1'b1; a0 = 8'd9;
    tick();
    st0 = 1'b0;
    ticks(2);
    start_op(0, 9);
    tick();
    drop_starts();
    @(negedge clk);
    chk("hold_sqrt_in_calc", longint'(s0), 10);
    chk("hold_rem_in_calc", longint'(r0), 0);
    ticks(4);
    ticks(2);

    // clr in the second calculation cycle aborts the operation.
    start_op(0, 200);
    tick();
    drop_starts();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 3; i++) sb[i].delete();
    @(negedge clk);
    chk("abort_done", longint'(d0), 0);
    chk("abort_sqrt", longint'(s0), 0);
    chk("abort_rem", longint'(r0), 0);
    tick();
    go(0, 49);
    tick();

    go(2, 65535);
    go(2, 10000);
    tick();

    for (int v = 0; v < 256; v++) begin
      start_op(0, longint'(v));
      start_op(1, longint'(v));
      tick();
      drop_starts();
      ticks(4);
    end
    ticks(2);

    for (int n = 0; n < 150; n++) begin
      start_op(2, longint'($urandom_range(65535, 0)));
      tick();
      drop_starts();
      if ($urandom_range(1, 0) == 1) begin
        tick();
        st2 = 1'b1;
        a2 = 16'($urandom_range(65535, 0));
        tick();
        st2 = 1'b0;
        ticks(6);
      end else begin
        ticks(8);
      end
      ticks($urandom_range(2, 0));
    end
    ticks(12);
    for (int i = 0; i < 3; i++) chk("left_in_queue", longint'(sb[i].size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
